des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 49 ++++
 rtl/des_pc2.sv | 24 ++
 rtl/des_key_schedule.sv | 171 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg -- shared constants for the DES key schedule.
//
// Holds the FIPS 46-3 permuted-choice tables, the per-round left-shift
// schedule, the fixed DES widths and the key-schedule FSM state type.
// Table entries use FIPS numbering: entry j-1 gives the source bit (1-based)
// for output bit j.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W  = 64;   // raw key incl. parity bits
    localparam int CD_W   = 56;   // PC-1 output, {C,D}
    localparam int SK_W   = 48;   // round subkey
    localparam int HALF_W = 28;   // each of C and D

    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount for rounds 1..16 (index 0..15).
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2 -- DES Permuted Choice 2, purely combinational (56 -> 48).
//
// Ports:
//   i_cd  [56:1]  {C,D} in FIPS numbering (bit 1 = C bit 1, bit 29 = D bit 1)
//   o_sk  [48:1]  round subkey in FIPS numbering
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W:1] i_cd,
    output logic [SK_W:1] o_sk
);

    for (genvar j = 1; j <= SK_W; j++) begin : g_bit
        assign o_sk[j] = i_cd[PC2_TAB[j-1]];
    end

    // PC-2 discards eight of the 56 bits by definition.
    logic [7:0] w_unused_dropped;
    assign w_unused_dropped = {i_cd[54], i_cd[43], i_cd[38], i_cd[35],
                               i_cd[25], i_cd[22], i_cd[18], i_cd[9]};

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule -- DES round-subkey generator with valid/ready handshakes.
//
// A key accepted in IDLE (key_vld && key_rdy) is run through PC-1; the C/D
// registers load the round-1 value on that edge, so K1 is presented on the
// next cycle.  Each accepted subkey (sk_vld && sk_rdy) advances one round;
// accepting the final subkey returns to IDLE, leaving one idle cycle before
// the next key can be taken.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   key_in     [64:1] key, key_in[i] = FIPS bit i (parity bits ignored)
//   key_vld    key_in valid
//   decrypt    reverse subkey order (only with DES_KEY_DECRYPT_EN)
//   key_rdy    block can accept a key (IDLE)
//   sk_out     [48:1] current subkey, FIPS numbering
//   sk_round   [4:1] subkey index, 0..15 for K1..K16
//   sk_vld     subkey outputs valid (RUN)
//   sk_rdy     consumer accepts the subkey
//   sk_last    current subkey is the last of the schedule
//
// Configuration macro: DES_KEY_DECRYPT_EN adds the decrypt port and the
// K16..K1 ordering; without it the block is encrypt-only.
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [KEY_W:1] key_in,
    input  logic           key_vld,
`ifdef DES_KEY_DECRYPT_EN
    input  logic           decrypt,
`endif
    output logic           key_rdy,
    output logic [SK_W:1]  sk_out,
    output logic [4:1]     sk_round,
    output logic           sk_vld,
    input  logic           sk_rdy,
    output logic           sk_last
);

    // Rotations in FIPS numbering: rotating left by s makes new bit i take
    // old bit i+s, which in a [28:1] vector moves bits toward index 1.
    function automatic logic [HALF_W:1] rot_l(input logic [HALF_W:1] v,
                                              input logic [1:0] s);
        return (s == 2'd2) ? {v[2:1], v[HALF_W:3]} : {v[1], v[HALF_W:2]};
    endfunction

    function automatic logic [HALF_W:1] rot_r(input logic [HALF_W:1] v,
                                              input logic [1:0] s);
        return (s == 2'd2) ? {v[HALF_W-2:1], v[HALF_W:HALF_W-1]}
                           : {v[HALF_W-1:1], v[HALF_W]};
    endfunction

    state_t            r_state, w_state_nxt;
    logic [HALF_W:1]   r_c, r_d, w_c_nxt, w_d_nxt;
    logic [4:1]        r_round, w_round_nxt;
    logic [4:1]        w_rnd_inc;
    logic [CD_W:1]     w_pc1;
    logic [HALF_W:1]   w_c0, w_d0;
    logic              w_dec, w_dec_req, w_last;

    for (genvar j = 1; j <= CD_W; j++) begin : g_pc1
        assign w_pc1[j] = key_in[PC1_TAB[j-1]];
    end

    assign w_c0 = w_pc1[HALF_W:1];
    assign w_d0 = w_pc1[CD_W:HALF_W+1];

    logic [7:0] w_unused_parity;
    assign w_unused_parity = {key_in[64], key_in[56], key_in[48], key_in[40],
                              key_in[32], key_in[24], key_in[16], key_in[8]};

`ifdef DES_KEY_DECRYPT_EN
    logic r_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec <= 1'b0;
        end else if (r_state == IDLE && key_vld) begin
            r_dec <= decrypt;
        end
    end

    assign w_dec     = r_dec;
    assign w_dec_req = decrypt;
`else
    assign w_dec     = 1'b0;
    assign w_dec_req = 1'b0;
`endif

    assign w_rnd_inc = r_round + 4'd1;
    assign w_last    = w_dec ? (r_round == 4'd0) : (r_round == 4'd15);
    assign sk_round  = r_round;

    // {D,C} in vector order is {C,D} in FIPS order: C occupies bits 1..28.
    des_pc2 u_pc2 (
        .i_cd (({r_d, r_c})),
        .o_sk (sk_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_round_nxt = r_round;
        key_rdy     = 1'b0;
        sk_vld      = 1'b0;
        sk_last     = 1'b0;
        case (r_state)
            IDLE: begin
                key_rdy = 1'b1;
                if (key_vld) begin
                    w_state_nxt = RUN;
                    if (w_dec_req) begin
                        // The shifts sum to 28, so K16 comes straight from C0/D0.
                        w_c_nxt     = w_c0;
                        w_d_nxt     = w_d0;
                        w_round_nxt = 4'd15;
                    end else begin
                        w_c_nxt     = rot_l(w_c0, SHIFT_TAB[0]);
                        w_d_nxt     = rot_l(w_d0, SHIFT_TAB[0]);
                        w_round_nxt = 4'd0;
                    end
                end
            end
            RUN: begin
                sk_vld  = 1'b1;
                sk_last = w_last;
                if (sk_rdy) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else if (w_dec) begin
                        // Undo the shift that produced the round being left.
                        w_c_nxt     = rot_r(r_c, SHIFT_TAB[r_round]);
                        w_d_nxt     = rot_r(r_d, SHIFT_TAB[r_round]);
                        w_round_nxt = r_round - 4'd1;
                    end else begin
                        w_c_nxt     = rot_l(r_c, SHIFT_TAB[w_rnd_inc]);
                        w_d_nxt     = rot_l(r_d, SHIFT_TAB[w_rnd_inc]);
                        w_round_nxt = w_rnd_inc;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
        end else begin
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_round <= w_round_nxt;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
`timescale 1ns/1ps
module tb_des_key_schedule;

`ifdef DES_KEY_DECRYPT_EN
    localparam bit HAS_DEC = 1'b1;
`else
    localparam bit HAS_DEC = 1'b0;
`endif

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    // Reference tables, conventional numbering (bit 1 = leftmost).
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst, key_vld, sk_rdy, decrypt;
    logic [64:1] key_in;
    logic        key_rdy, sk_vld, sk_last;
    logic [48:1] sk_out;
    logic [4:1]  sk_round;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_vld  (key_vld),
`ifdef DES_KEY_DECRYPT_EN
        .decrypt  (decrypt),
`endif
        .key_rdy  (key_rdy),
        .sk_out   (sk_out),
        .sk_round (sk_round),
        .sk_vld   (sk_vld),
        .sk_rdy   (sk_rdy),
        .sk_last  (sk_last)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int j = 0; j < 56; j++) o[6'(55 - j)] = k[6'(64 - PC1_T[j])];
        return o;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input int s);
        return (v << s) | (v >> (28 - s));
    endfunction

    // Subkey r (0-based) straight from the cumulative rotation of C0/D0.
    function automatic logic [47:0] subkey(input logic [63:0] k, input int r);
        logic [55:0] cd, cdr;
        logic [47:0] o;
        int s;
        s = 0;
        for (int i = 0; i <= r; i++) s += SH_T[i];
        s = s % 28;
        cd  = pc1(k);
        cdr = {rotl(cd[55:28], s), rotl(cd[27:0], s)};
        o = '0;
        for (int j = 0; j < 48; j++) o[6'(47 - j)] = cdr[6'(56 - PC2_T[j])];
        return o;
    endfunction

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    bit          sb_busy = 1'b0;
    logic [47:0] sb_conv;
    logic [63:0] sb_key;

    // One compare per cycle, then advance the model with the inputs the
    // DUT will see on the coming rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("key_rdy", key_rdy, !sb_busy);
            chk("sk_vld", sk_vld, sb_busy);
            if (sb_busy && sk_vld) begin
                sb_conv = {<<{sk_out}};
                chk("sk_out", sb_conv, sb_q[0].sk);
                chk("sk_round", sk_round, sb_q[0].rnd);
                chk("sk_last", sk_last, sb_q[0].last);
            end
            if (rst) begin
                sb_q.delete();
                sb_busy = 1'b0;
            end else if (!sb_busy && key_vld) begin
                exp_t e;
                bit   d;
                d = HAS_DEC && decrypt;
                sb_key = {<<{key_in}};
                for (int r = 0; r < 16; r++) begin
                    e.sk   = d ? subkey(sb_key, 15 - r) : subkey(sb_key, r);
                    e.rnd  = d ? 4'(15 - r) : 4'(r);
                    e.last = (r == 15);
                    sb_q.push_back(e);
                end
                sb_busy = 1'b1;
            end else if (sb_busy && sk_rdy) begin
                void'(sb_q.pop_front());
                if (sb_q.size() == 0) sb_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [47:0] drv_conv;

    task automatic run_key(input logic [63:0] k, input bit dec, input bit rnd_rdy,
                           input bit noise, input bit chk_first,
                           input logic [47:0] first_sk, input logic [3:0] first_rnd);
        int n;
        n = 0;
        while (!key_rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_rdy) begin
            chk("key_rdy_timeout", key_rdy, 1);
            return;
        end
        key_in  = {<<{k}};
        decrypt = dec;
        key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
        sk_rdy  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (chk_first) begin
            @(negedge clk);
            drv_conv = {<<{sk_out}};
            chk("first_sk_out", drv_conv, first_sk);
            chk("first_sk_round", sk_round, first_rnd);
            chk("first_sk_vld", sk_vld, 1);
        end
        n = 0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (!sb_busy) break;
            sk_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                key_vld = 1'($urandom_range(0, 1));
                key_in  = {$urandom, $urandom};
                decrypt = 1'($urandom_range(0, 1));
            end
        end
        key_vld = 1'b0;
        sk_rdy  = 1'b0;
        decrypt = 1'b0;
        if (sb_busy) chk("schedule_timeout", sb_busy, 0);
        chk("key_rdy_after_last", key_rdy, 1);
        chk("sk_vld_bubble", sk_vld, 0);
    endtask

    initial begin
        logic [55:0] pc;
        int n;
        rst = 1'b1; key_vld = 1'b0; sk_rdy = 1'b0; decrypt = 1'b0; key_in = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_sk_round", sk_round, 0);
        chk("rst_sk_last", sk_last, 0);
        chk("rst_sk_vld", sk_vld, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("key_rdy_after_rst", key_rdy, 1);

        // Pin the model to published values.
        pc = pc1(KEY_A);
        chk("model_C0", pc[55:28], 28'hF0CCAAF);
        chk("model_D0", pc[27:0], 28'h556678F);
        chk("model_K1", subkey(KEY_A, 0), 48'h1B02EFFC7072);
        chk("model_K2", subkey(KEY_A, 1), 48'h79AED9DBC9E5);
        chk("model_K16", subkey(KEY_A, 15), 48'hCB3D8B0E17F5);
        chk("model_zero", subkey(64'h0, 7), 48'h0);
        chk("model_ones", subkey(64'hFFFFFFFFFFFFFFFF, 9), 48'hFFFFFFFFFFFF);

        // Reference key, consumer always ready.
        run_key(KEY_A, 1'b0, 1'b0, 1'b0, 1'b1, 48'h1B02EFFC7072, 4'd0);
        // Same key with random stalls.
        run_key(KEY_A, 1'b0, 1'b1, 1'b0, 1'b1, 48'h1B02EFFC7072, 4'd0);

        // Reset in the middle of the schedule, with key_vld and sk_rdy high.
        @(posedge clk); #1;
        key_in = {<<{KEY_A}}; key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0; sk_rdy = 1'b1;
        n = 0;
        while (!(sk_vld && sk_round == 4'd7) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_round7", sk_round, 7);
        rst = 1'b1; key_vld = 1'b1; key_in = {$urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b0; key_vld = 1'b0; sk_rdy = 1'b0;
        @(negedge clk);
        chk("abort_sk_vld", sk_vld, 0);
        chk("abort_sk_round", sk_round, 0);
        run_key(KEY_A, 1'b0, 1'b0, 1'b0, 1'b1, 48'h1B02EFFC7072, 4'd0);

        // Reset in IDLE wins over key_vld.
        @(posedge clk); #1;
        rst = 1'b1; key_vld = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; key_vld = 1'b0;
        @(negedge clk);
        chk("rst_prio_sk_vld", sk_vld, 0);

        run_key(64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 48'h0, 4'd0);
        run_key(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 4'd0);

        if (HAS_DEC) begin
            run_key(KEY_A, 1'b1, 1'b0, 1'b0, 1'b1, 48'hCB3D8B0E17F5, 4'd15);
            run_key(KEY_A, 1'b1, 1'b1, 1'b1, 1'b1, 48'hCB3D8B0E17F5, 4'd15);
        end

        for (int i = 0; i < 10; i++) begin
            run_key({$urandom, $urandom}, HAS_DEC && 1'($urandom_range(0, 1)),
                    1'b1, 1'b1, 1'b0, 48'h0, 4'd0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
